// File: rtl/cxu_dispatch.sv
// cxu_dispatch: accepts one CPU CXU command, routes it to the CXU named by cxu_id, returns its result.
// Define CXU_DISPATCH_TIMEOUT_EN to bound the wait on a CXU with an error response after TIMEOUT_CYCLES.
module cxu_dispatch #(
   parameter int unsigned NUM_CXU        = 2,
   parameter logic [31:0] ERR_VALUE      = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned DATA_W        = 32,
   localparam int unsigned FUNC_W        = 3,
   localparam int unsigned STATE_W       = 3,
   localparam int unsigned ID_W          = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [FUNC_W-1:0]           cmd_payload_function_id,
   input  logic [DATA_W-1:0]           cmd_payload_inputs_0,
   input  logic [DATA_W-1:0]           cmd_payload_inputs_1,
   input  logic [STATE_W-1:0]          cmd_payload_state_id,
   input  logic [ID_W-1:0]             cmd_payload_cxu_id,
   input  logic                        cmd_payload_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_payload_outputs_0,
   output logic                        rsp_payload_ready,
   output logic [NUM_CXU-1:0]          cxu_cmd_valid,
   input  logic [NUM_CXU-1:0]          cxu_cmd_ready,
   output logic [FUNC_W-1:0]           cxu_cmd_payload_function_id,
   output logic [DATA_W-1:0]           cxu_cmd_payload_inputs_0,
   output logic [DATA_W-1:0]           cxu_cmd_payload_inputs_1,
   output logic [STATE_W-1:0]          cxu_cmd_payload_state_id,
   input  logic [NUM_CXU-1:0]          cxu_rsp_valid,
   output logic [NUM_CXU-1:0]          cxu_rsp_ready,
   input  logic [NUM_CXU*DATA_W-1:0]   cxu_rsp_payload_outputs_0,
   output logic                        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state, state_n;
   logic [ID_W-1:0]      sel, sel_n;
   logic [DATA_W-1:0]    result_n;
   logic [FUNC_W-1:0]    func_n;
   logic [STATE_W-1:0]   sid_n;
   logic [DATA_W-1:0]    in0_n, in1_n;
   logic                 prdy_n;
   logic [NUM_CXU-1:0]   sel_oh_n;
   logic [NUM_CXU-1:0]   cxu_cmd_valid_n, cxu_rsp_ready_n;
   logic                 cmd_ready_n, rsp_valid_n, busy_n;
   logic                 cmd_hs, rsp_hs, expire;
   logic [DATA_W-1:0]    rsp_data;

   // Handshakes only ever involve the selected CXU since the other valid/ready bits are held low.
   assign cmd_hs = |(cxu_cmd_valid & cxu_cmd_ready);
   assign rsp_hs = |(cxu_rsp_valid & cxu_rsp_ready);

   // Result word of the selected CXU.
   always_comb begin
      rsp_data = '0;
      for (int unsigned k = 0; k < NUM_CXU; k++) begin
         if (sel == ID_W'(k)) rsp_data = cxu_rsp_payload_outputs_0[k*DATA_W +: DATA_W];
      end
   end

`ifdef CXU_DISPATCH_TIMEOUT_EN
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt;

   // Counts cycles spent waiting on the CXU; zero whenever a new command enters ISSUE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                               tmo_cnt <= '0;
      else if (state == IDLE)                   tmo_cnt <= '0;
      else if (state == ISSUE || state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
   end

   assign expire = (state == ISSUE || state == WAIT) && (tmo_cnt == TMO_LAST);
`else
   localparam int unsigned tmo_cycles_unused = TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   // Next state, latched command fields and next registered outputs.
   always_comb begin
      state_n  = state;
      sel_n    = sel;
      result_n = rsp_payload_outputs_0;
      func_n   = cxu_cmd_payload_function_id;
      sid_n    = cxu_cmd_payload_state_id;
      in0_n    = cxu_cmd_payload_inputs_0;
      in1_n    = cxu_cmd_payload_inputs_1;
      prdy_n   = rsp_payload_ready;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               sel_n  = cmd_payload_cxu_id;
               func_n = cmd_payload_function_id;
               sid_n  = cmd_payload_state_id;
               in0_n  = cmd_payload_inputs_0;
               in1_n  = cmd_payload_inputs_1;
               prdy_n = cmd_payload_ready;
               if (32'(cmd_payload_cxu_id) < NUM_CXU) begin
                  state_n = ISSUE;
               end else begin
                  result_n = ERR_VALUE;
                  state_n  = RESP;
               end
            end
         end
         ISSUE: begin
            // A response without the command handshake is dropped.
            if (cmd_hs && rsp_hs) begin
               result_n = rsp_data;
               state_n  = RESP;
            end else if (cmd_hs) begin
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (rsp_hs) begin
               result_n = rsp_data;
               state_n  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A response on the expiry cycle has already moved us to RESP and wins.
      if (expire && state_n != RESP) begin
         result_n = ERR_VALUE;
         state_n  = RESP;
      end

      for (int unsigned k = 0; k < NUM_CXU; k++) begin
         sel_oh_n[k] = (sel_n == ID_W'(k));
      end

      cmd_ready_n     = (state_n == IDLE);
      rsp_valid_n     = (state_n == RESP);
      busy_n          = (state_n != IDLE);
      cxu_cmd_valid_n = (state_n == ISSUE) ? sel_oh_n : '0;
      cxu_rsp_ready_n = (state_n == ISSUE || state_n == WAIT) ? sel_oh_n : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                       <= IDLE;
         sel                         <= '0;
         cmd_ready                   <= 1'b0;
         rsp_valid                   <= 1'b0;
         busy                        <= 1'b0;
         rsp_payload_outputs_0       <= '0;
         rsp_payload_ready           <= 1'b0;
         cxu_cmd_valid               <= '0;
         cxu_rsp_ready               <= '0;
         cxu_cmd_payload_function_id <= '0;
         cxu_cmd_payload_inputs_0    <= '0;
         cxu_cmd_payload_inputs_1    <= '0;
         cxu_cmd_payload_state_id    <= '0;
      end else begin
         state                       <= state_n;
         sel                         <= sel_n;
         cmd_ready                   <= cmd_ready_n;
         rsp_valid                   <= rsp_valid_n;
         busy                        <= busy_n;
         rsp_payload_outputs_0       <= result_n;
         rsp_payload_ready           <= prdy_n;
         cxu_cmd_valid               <= cxu_cmd_valid_n;
         cxu_rsp_ready               <= cxu_rsp_ready_n;
         cxu_cmd_payload_function_id <= func_n;
         cxu_cmd_payload_inputs_0    <= in0_n;
         cxu_cmd_payload_inputs_1    <= in1_n;
         cxu_cmd_payload_state_id    <= sid_n;
      end
   end

endmodule

// File: tb/tb_cxu_dispatch.sv
// Scoreboard bench for cxu_dispatch: CXU0 is a combinational Q10 multiplier, CXU1 a multi-cycle adder.
// Build with CXU_DISPATCH_TIMEOUT_EN defined to also exercise the timeout with TIMEOUT_CYCLES=8.
module tb_cxu_dispatch;
   localparam int unsigned NUM_CXU = 2;
   localparam logic [31:0] ERR     = 32'hFFFF_FFFF;
`ifdef CXU_DISPATCH_TIMEOUT_EN
   localparam int unsigned TMO    = 8;
   localparam bit          TMO_EN = 1'b1;
`else
   localparam int unsigned TMO    = 256;
   localparam bit          TMO_EN = 1'b0;
`endif

   logic clk, reset;
   logic cmd_valid, cmd_ready, cmd_payload_ready;
   logic [2:0] cmd_payload_function_id, cmd_payload_state_id;
   logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
   logic [3:0] cmd_payload_cxu_id;
   logic rsp_valid, rsp_ready, rsp_payload_ready, busy;
   logic [31:0] rsp_payload_outputs_0;
   logic [NUM_CXU-1:0] cxu_cmd_valid, cxu_rsp_ready;
   logic [2:0] cxu_cmd_payload_function_id, cxu_cmd_payload_state_id;
   logic [31:0] cxu_cmd_payload_inputs_0, cxu_cmd_payload_inputs_1;

   logic c0_cmd_ready, c0_rsp_valid, c1_cmd_ready, c1_rsp_valid;
   logic [31:0] c0_data, c1_data;

   cxu_dispatch #(.NUM_CXU(NUM_CXU), .ERR_VALUE(ERR), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(cmd_payload_function_id),
      .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
      .cmd_payload_state_id(cmd_payload_state_id), .cmd_payload_cxu_id(cmd_payload_cxu_id),
      .cmd_payload_ready(cmd_payload_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_payload_outputs_0(rsp_payload_outputs_0), .rsp_payload_ready(rsp_payload_ready),
      .cxu_cmd_valid(cxu_cmd_valid), .cxu_cmd_ready({c1_cmd_ready, c0_cmd_ready}),
      .cxu_cmd_payload_function_id(cxu_cmd_payload_function_id),
      .cxu_cmd_payload_inputs_0(cxu_cmd_payload_inputs_0),
      .cxu_cmd_payload_inputs_1(cxu_cmd_payload_inputs_1),
      .cxu_cmd_payload_state_id(cxu_cmd_payload_state_id),
      .cxu_rsp_valid({c1_rsp_valid, c0_rsp_valid}), .cxu_rsp_ready(cxu_rsp_ready),
      .cxu_rsp_payload_outputs_0({c1_data, c0_data}),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] q10(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'(signed'(a)) * longint'(signed'(b));
      return 32'(p >>> 10);
   endfunction

   // Reference model: what the CPU must see for a command, and how many cycles after the accept cycle.
   function automatic logic [31:0] ref_result(input int id, input logic [31:0] a, input logic [31:0] b,
                                              input int s, input int d);
      if (id >= int'(NUM_CXU)) return ERR;
      if (id == 0) return q10(a, b);
      if (TMO_EN && (s + d + 2 > int'(TMO))) return ERR;
      return a + b;
   endfunction

   function automatic int ref_latency(input int id, input int s, input int d);
      if (id >= int'(NUM_CXU)) return 1;
      if (id == 0) return 2;
      if (TMO_EN && (s + d + 2 > int'(TMO))) return 1 + int'(TMO);
      return 3 + s + d;
   endfunction

   // CXU0: combinational, ready/valid tied through.
   assign c0_cmd_ready = cxu_rsp_ready[0];
   assign c0_rsp_valid = cxu_cmd_valid[0];
   assign c0_data      = q10(cxu_cmd_payload_inputs_0, cxu_cmd_payload_inputs_1);

   // CXU1: stalls the command c1_stall cycles, then answers c1_delay cycles into WAIT.
   int c1_stall = 0, c1_delay = 0;
   initial begin
      c1_cmd_ready = 1'b0;
      c1_rsp_valid = 1'b0;
      c1_data      = '0;
      forever begin
         @(negedge clk);
         if (cxu_cmd_valid[1]) begin
            logic [31:0] sum;
            repeat (c1_stall) @(negedge clk);
            c1_cmd_ready = 1'b1;
            sum = cxu_cmd_payload_inputs_0 + cxu_cmd_payload_inputs_1;
            @(negedge clk);
            c1_cmd_ready = 1'b0;
            repeat (c1_delay) @(negedge clk);
            c1_rsp_valid = 1'b1;
            c1_data      = sum;
            @(negedge clk);
            c1_rsp_valid = 1'b0;
            c1_data      = '0;
         end
      end
   end

   typedef struct {
      logic [31:0] data;
      logic        prdy;
      int          lat;
      int          hold;
      int          acc;
   } exp_t;
   exp_t sb[$];

   logic [NUM_CXU-1:0] cur_allow = '0;
   bit in_resp = 0, acc_pending = 0;

   // Monitor and CPU response sink.
   initial begin
      exp_t e;
      int hold_left;
      logic [31:0] held;
      logic held_prdy;
      rsp_ready = 1'b0;
      hold_left = 0;
      held = '0;
      held_prdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            in_resp = 0;
            acc_pending = 0;
            rsp_ready = 1'b0;
         end else begin
            chk("cxu_select", 64'((cxu_cmd_valid | cxu_rsp_ready) & ~cur_allow), 64'(0));
            if (acc_pending) begin
               chk("rsp_valid_after_accept", 64'(rsp_valid), 64'(0));
               chk("cmd_ready_after_accept", 64'(cmd_ready), 64'(1));
               acc_pending = 0;
            end
            if (rsp_valid) begin
               if (!in_resp) begin
                  if (sb.size() == 0) begin
                     chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                     hold_left = 0;
                  end else begin
                     e = sb.pop_front();
                     chk("rsp_data", 64'(rsp_payload_outputs_0), 64'(e.data));
                     chk("rsp_prdy", 64'(rsp_payload_ready), 64'(e.prdy));
                     chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                     hold_left = e.hold;
                  end
                  in_resp   = 1;
                  held      = rsp_payload_outputs_0;
                  held_prdy = rsp_payload_ready;
               end else begin
                  chk("rsp_data_stable", 64'(rsp_payload_outputs_0), 64'(held));
                  chk("rsp_prdy_stable", 64'(rsp_payload_ready), 64'(held_prdy));
                  chk("cmd_ready_in_resp", 64'(cmd_ready), 64'(0));
               end
               if (hold_left > 0) begin
                  rsp_ready = 1'b0;
                  hold_left--;
               end else begin
                  rsp_ready   = 1'b1;
                  acc_pending = 1;
                  in_resp     = 0;
               end
            end else begin
               rsp_ready = 1'b0;
            end
         end
      end
   end

   task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] fid, input logic [2:0] sid, input logic prdy,
                       input int s, input int d, input int hold, input bit push);
      int n;
      logic [NUM_CXU-1:0] oh;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
      oh = (id < int'(NUM_CXU)) ? NUM_CXU'(1 << id) : '0;
      c1_stall  = s;
      c1_delay  = d;
      cur_allow = oh;
      cmd_payload_cxu_id      = 4'(id);
      cmd_payload_inputs_0    = a;
      cmd_payload_inputs_1    = b;
      cmd_payload_function_id = fid;
      cmd_payload_state_id    = sid;
      cmd_payload_ready       = prdy;
      cmd_valid               = 1'b1;
      if (push) sb.push_back('{ref_result(id, a, b, s, d), prdy, ref_latency(id, s, d), hold, cyc});
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cxu_cmd_valid_issue", 64'(cxu_cmd_valid), 64'(oh));
      chk("bcast_in0", 64'(cxu_cmd_payload_inputs_0), 64'(a));
      chk("bcast_in1", 64'(cxu_cmd_payload_inputs_1), 64'(b));
      chk("bcast_fid", 64'(cxu_cmd_payload_function_id), 64'(fid));
      chk("bcast_sid", 64'(cxu_cmd_payload_state_id), 64'(sid));
      chk("busy_after_accept", 64'(busy), 64'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_payload_cxu_id = '0;
      cmd_payload_inputs_0 = '0;
      cmd_payload_inputs_1 = '0;
      cmd_payload_function_id = '0;
      cmd_payload_state_id = '0;
      cmd_payload_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_cxu_vr", 64'({cxu_cmd_valid, cxu_rsp_ready}), 64'(0));
      chk("reset_payloads", 64'({rsp_payload_outputs_0, rsp_payload_ready}), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

      // Directed cases.
      send(0, 32'h0000_0800, 32'h0000_0C00, 3'd1, 3'd2, 1'b1, 0, 0, 0, 1);
      send(1, 32'h1234_0000, 32'h0000_5678, 3'd5, 3'd3, 1'b0, 0, 4, 0, 1);
      send(7, 32'hAAAA_5555, 32'h0F0F_F0F0, 3'd0, 3'd0, 1'b1, 0, 0, 0, 1);
      send(0, 32'hFFFF_F000, 32'h0000_1400, 3'd7, 3'd7, 1'b1, 0, 0, 4, 1);
      send(2, 32'h1, 32'h2, 3'd2, 3'd4, 1'b0, 0, 0, 1, 1);
      send(15, 32'h3, 32'h4, 3'd3, 3'd5, 1'b1, 0, 0, 0, 1);
      send(1, 32'h8000_0000, 32'h8000_0001, 3'd6, 3'd1, 1'b1, 2, 0, 2, 1);

      // Reset while waiting on CXU1: no response may ever appear for it.
      send(1, 32'h0BAD_0000, 32'h0000_0BAD, 3'd1, 3'd1, 1'b1, 0, 6, 0, 0);
      repeat (2) @(negedge clk);
      chk("in_wait", 64'({cxu_cmd_valid, cxu_rsp_ready}), 64'({2'b00, 2'b10}));
      reset = 1'b0;
      #1;
      chk("async_rst_ctrl", 64'({cmd_ready, rsp_valid, busy}), 64'(0));
      chk("async_rst_cxu", 64'({cxu_cmd_valid, cxu_rsp_ready}), 64'(0));
      chk("async_rst_data", 64'({rsp_payload_outputs_0, cxu_cmd_payload_inputs_0}), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rerst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rerst_rsp_valid", 64'(rsp_valid), 64'(0));
      repeat (12) @(negedge clk);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         int r, id;
         r  = int'($urandom_range(0, 9));
         id = (r < 4) ? 0 : (r < 8) ? 1 : int'($urandom_range(2, 15));
         send(id, $urandom, $urandom, 3'($urandom), 3'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), 1);
      end

      if (TMO_EN) begin
         // Response on the expiry cycle, then a CXU that answers far too late.
         send(1, 32'h10, 32'h20, 3'd1, 3'd1, 1'b1, 0, int'(TMO) - 2, 0, 1);
         send(1, 32'h30, 32'h40, 3'd2, 3'd2, 1'b0, 0, 30, 0, 1);
         repeat (40) @(negedge clk);
      end

      n = 0;
      while ((sb.size() != 0 || in_resp || acc_pending) && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
